// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clock-ratio monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_mon_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } mon_state_t;

  // Bit positions inside err_flags
  localparam int ERR_CLK_2F = 0;
  localparam int ERR_CLK_F  = 1;
  localparam int ERR_PHASE  = 2;
  localparam int ERR_STUCK  = 3;

  // Width of an interval counter that must be able to hold TIMEOUT itself
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/edge_meter.sv
// Samples one monitored clock as data and measures the spacing of its edges.
// Latency: edge flags valid 1 cycle after the input changes (sample register).
// Backpressure: none; free-running on every clk_8f cycle.
module edge_meter
  import clk_mon_pkg::*;
#(
  parameter int HALF    = 2,
  parameter int TIMEOUT = 32
) (
  input  logic clk_8f,
  input  logic rst,
  input  logic clr,
  input  logic sig,
  output logic edge_det,
  output logic rise,
  output logic interval_ok,
  output logic stuck,
  output logic armed
);

  localparam int            CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  // Counter reads (edge spacing - 1) on the cycle the next edge is seen
  localparam logic [CW-1:0] CNT_OK  = CW'(HALF - 1);

  logic          s;
  logic          s_d;
  logic [CW-1:0] cnt;
  logic          first_seen;

  // Sample register plus one-cycle history for edge detection
  always_ff @(posedge clk_8f) begin
    if (rst) begin
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s   <= sig;
      s_d <= s;
    end
  end

  assign edge_det = s ^ s_d;
  assign rise     = s & ~s_d;

  // Saturating cycles-since-last-edge counter; held at zero while the monitor idles
  always_ff @(posedge clk_8f) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (edge_det) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // First edge after idle only opens the measurement window
  always_ff @(posedge clk_8f) begin
    if (rst || clr) begin
      first_seen <= 1'b0;
    end else if (edge_det) begin
      first_seen <= 1'b1;
    end
  end

  assign interval_ok = (cnt == CNT_OK);
  assign stuck       = (cnt == CNT_MAX);
  assign armed       = first_seen;

endmodule

// File: rtl/clk_ratio_mon.sv
// Checks clk_2f/clk_f half-periods and phase against clk_8f; locks, then latches faults.
// Latency: input change -> detected edge 1 cycle, detected edge -> lock/fault/err_flags 1 cycle.
// Backpressure: none; every cycle is evaluated, enb low returns to IDLE.
module clk_ratio_mon
  import clk_mon_pkg::*;
#(
  parameter int HALF_2F  = 2,
  parameter int HALF_F   = 4,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 32
) (
  input  logic       clk_8f,
  input  logic       rst,
  input  logic       enb,
  input  logic       clk_2f_in,
  input  logic       clk_f_in,
  output logic       lock,
  output logic       fault,
  output logic [3:0] err_flags
);

  localparam int            GW        = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);

  mon_state_t    state;
  logic [GW-1:0] good_cnt;

  logic p_edge, p_rise, p_ok, p_stuck, p_armed;
  logic f_edge, f_ok, f_stuck, f_armed;
  logic f_rise_unused;
  logic [3:0] cause;
  logic any_viol;
  logic good_edge;

  edge_meter #(.HALF(HALF_2F), .TIMEOUT(TIMEOUT)) u_meter_2f (
    .clk_8f      (clk_8f),
    .rst         (rst),
    .clr         (state == IDLE),
    .sig         (clk_2f_in),
    .edge_det    (p_edge),
    .rise        (p_rise),
    .interval_ok (p_ok),
    .stuck       (p_stuck),
    .armed       (p_armed)
  );

  edge_meter #(.HALF(HALF_F), .TIMEOUT(TIMEOUT)) u_meter_f (
    .clk_8f      (clk_8f),
    .rst         (rst),
    .clr         (state == IDLE),
    .sig         (clk_f_in),
    .edge_det    (f_edge),
    .rise        (f_rise_unused),
    .interval_ok (f_ok),
    .stuck       (f_stuck),
    .armed       (f_armed)
  );

  // Per-cycle violation causes; a clk_f edge must land on a clk_2f rising edge
  always_comb begin
    cause             = '0;
    cause[ERR_CLK_2F] = p_edge & p_armed & ~p_ok;
    cause[ERR_CLK_F]  = f_edge & f_armed & ~f_ok;
    cause[ERR_PHASE]  = f_edge & f_armed & ~p_rise;
    cause[ERR_STUCK]  = p_stuck | f_stuck;
  end

  assign any_viol  = |cause;
  assign good_edge = f_edge & f_armed & ~any_viol;

  // Monitor FSM with registered lock/fault/err_flags; enb low wins over every transition
  always_ff @(posedge clk_8f) begin
    if (rst || !enb) begin
      state     <= IDLE;
      good_cnt  <= '0;
      lock      <= 1'b0;
      fault     <= 1'b0;
      err_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= ACQUIRE;
          good_cnt <= '0;
        end
        ACQUIRE: begin
          if (any_viol) begin
            good_cnt <= '0;
          end else if (good_edge) begin
            if (good_cnt == GOOD_LAST) begin
              state    <= LOCKED;
              lock     <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (any_viol) begin
            state     <= FAULT;
            lock      <= 1'b0;
            fault     <= 1'b1;
            err_flags <= cause;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
